tag_lookup_ctrl: RTL and testbench

Sequencing controller for the 2-way tag array wrapper. It accepts lookup requests and issues the SRAM read. It compares both returned tags against the request tag, using per-set valid bits and per-set LRU bits held in flops. It reports hit or miss with the victim way, then issues the tag write to the victim way when the line fill completes. It sits between the cache FSM and the tag array; it is the only master of the array's A, DI, WEB, CEB and i_WAY inputs.

---
 rtl/tag_lookup_ctrl.sv | 158 +++++++++++++++
 tb/tb_tag_lookup_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_ctrl.sv
// Lookup/fill sequencer for the 2-way tag array.
// Owns per-set valid and LRU state; sole master of the array port.
module tag_lookup_ctrl #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 23,
    parameter int IDX_W  = 5,
    parameter int OFF_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              flush_done,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic              rsp_way,
    input  logic              fill_valid,
    output logic              fill_done,
    output logic [IDX_W-1:0]  ta_A,
    output logic [TAG_W-1:0]  ta_DI,
    output logic              ta_WEB,
    output logic              ta_CEB,
    output logic              ta_WAY,
    input  logic [TAG_W-1:0]  ta_TAG1,
    input  logic [TAG_W-1:0]  ta_TAG2
);

    localparam int SETS = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RESP,
        MISS,
        FILLDONE
    } state_t;

    state_t            state;
    logic [SETS-1:0]   vld0;
    logic [SETS-1:0]   vld1;
    logic [SETS-1:0]   lru;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic              victim_q;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              unused_off;
    logic              idle;
    logic              accept;
    logic              write;
    logic              hit0;
    logic              hit1;
    logic              victim;

    assign req_idx    = req_addr[OFF_W +: IDX_W];
    assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
    assign unused_off = ^req_addr[OFF_W-1:0];

    // Array strobes decode from state so reset silences them at once.
    always_comb begin
        idle      = (state == IDLE);
        accept    = rst & idle & req_valid & ~flush;
        write     = (state == MISS) & fill_valid;
        req_ready = rst & idle;
        ta_CEB    = ~(accept | write);
        ta_WEB    = ~write;
        ta_WAY    = write & victim_q;
        ta_DI     = write ? tag_q : '0;
        ta_A      = '0;
        if (accept) begin
            ta_A = req_idx;
        end else if (write) begin
            ta_A = idx_q;
        end
    end

    // Tag compare and victim choice against the read data in LOOKUP.
    always_comb begin
        hit0 = vld0[idx_q] & (ta_TAG1 == tag_q);
        hit1 = vld1[idx_q] & (ta_TAG2 == tag_q);
        if (!vld0[idx_q]) begin
            victim = 1'b0;
        end else if (!vld1[idx_q]) begin
            victim = 1'b1;
        end else begin
            victim = lru[idx_q];
        end
    end

    // Sequencer, set state and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            vld0       <= '0;
            vld1       <= '0;
            lru        <= '0;
            tag_q      <= '0;
            idx_q      <= '0;
            victim_q   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_way    <= 1'b0;
            flush_done <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            rsp_valid  <= 1'b0;
            flush_done <= 1'b0;
            fill_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (flush) begin
                        vld0       <= '0;
                        vld1       <= '0;
                        lru        <= '0;
                        flush_done <= 1'b1;
                    end else if (req_valid) begin
                        tag_q <= req_tag;
                        idx_q <= req_idx;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    rsp_valid <= 1'b1;
                    rsp_hit   <= hit0 | hit1;
                    rsp_way   <= hit0 ? 1'b0 : (hit1 ? 1'b1 : victim);
                    victim_q  <= victim;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_hit) begin
                        lru[idx_q] <= ~rsp_way;
                        state      <= IDLE;
                    end else begin
                        state <= MISS;
                    end
                end
                MISS: begin
                    if (fill_valid) begin
                        if (victim_q) begin
                            vld1[idx_q] <= 1'b1;
                        end else begin
                            vld0[idx_q] <= 1'b1;
                        end
                        lru[idx_q] <= ~victim_q;
                        fill_done  <= 1'b1;
                        state      <= FILLDONE;
                    end
                end
                FILLDONE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Random + directed bench for tag_lookup_ctrl.
// Per-cycle expectations come from a set-state model of the cache.
module tb_tag_lookup_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        flush_done;
    logic        rsp_valid;
    logic        rsp_hit;
    logic        rsp_way;
    logic        fill_valid;
    logic        fill_done;
    logic [4:0]  ta_A;
    logic [22:0] ta_DI;
    logic        ta_WEB;
    logic        ta_CEB;
    logic        ta_WAY;
    logic [22:0] ta_TAG1;
    logic [22:0] ta_TAG2;

    tag_lookup_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .flush(flush),
        .flush_done(flush_done), .rsp_valid(rsp_valid),
        .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .fill_valid(fill_valid), .fill_done(fill_done),
        .ta_A(ta_A), .ta_DI(ta_DI), .ta_WEB(ta_WEB),
        .ta_CEB(ta_CEB), .ta_WAY(ta_WAY),
        .ta_TAG1(ta_TAG1), .ta_TAG2(ta_TAG2)
    );

    always #5 clk = ~clk;

    // Reference state: what the cache should believe about each set.
    bit          mv[32][2];
    bit          mlru[32];
    logic [22:0] mtag[32][2];

    // Expected outputs for the current cycle.
    logic        exp_ready, exp_ceb, exp_web, exp_rspv;
    logic        exp_hit, exp_rway, exp_fd, exp_fl, exp_way;
    logic [4:0]  exp_a;
    logic [22:0] exp_di;
    bit          exp_chk_a, exp_chk_way, exp_rst;
    bit          chk_en = 0;
    bit          pend_fd = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, want %0h",
                     nm, $time, act, exp);
        end
    endtask

    // Single compare point, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("ta_CEB", 32'(ta_CEB), 32'(exp_ceb));
            chk("ta_WEB", 32'(ta_WEB), 32'(exp_web));
            chk("ta_DI", 32'(ta_DI), 32'(exp_di));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rspv));
            chk("flush_done", 32'(flush_done), 32'(exp_fd));
            chk("fill_done", 32'(fill_done), 32'(exp_fl));
            if (exp_rspv) begin
                chk("rsp_hit", 32'(rsp_hit), 32'(exp_hit));
                chk("rsp_way", 32'(rsp_way), 32'(exp_rway));
            end
            if (exp_chk_a)
                chk("ta_A", 32'(ta_A), 32'(exp_a));
            if (exp_chk_way)
                chk("ta_WAY", 32'(ta_WAY), 32'(exp_way));
            if (exp_rst) begin
                chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
                chk("rst_rsp_way", 32'(rsp_way), 32'd0);
            end
        end
    end

    task automatic model_clear();
        for (int s = 0; s < 32; s++) begin
            mv[s][0] = 0;
            mv[s][1] = 0;
            mlru[s]  = 0;
        end
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        flush       = 1'b0;
        fill_valid  = 1'($urandom);
        req_addr    = $urandom;
        ta_TAG1     = 23'($urandom);
        ta_TAG2     = 23'($urandom);
        exp_ready   = 1'b0;
        exp_ceb     = 1'b1;
        exp_web     = 1'b1;
        exp_di      = '0;
        exp_rspv    = 1'b0;
        exp_hit     = 1'b0;
        exp_rway    = 1'b0;
        exp_fl      = 1'b0;
        exp_fd      = pend_fd;
        pend_fd     = 0;
        exp_a       = '0;
        exp_way     = 1'b0;
        exp_chk_a   = 0;
        exp_chk_way = 0;
        exp_rst     = 0;
    endtask

    // Inputs the controller must ignore while busy.
    task automatic noise();
        req_valid = 1'($urandom);
        flush     = 1'($urandom);
    endtask

    task automatic idle_cycle(input bit fv);
        begin_cycle();
        fill_valid = fv;
        exp_ready  = 1'b1;
    endtask

    task automatic reset_cycle(input logic fv);
        begin_cycle();
        rst         = 1'b0;
        fill_valid  = fv;
        req_valid   = 1'b1;
        exp_chk_a   = 1;
        exp_chk_way = 1;
        exp_rst     = 1;
        model_clear();
    endtask

    task automatic do_flush(input logic rv);
        begin_cycle();
        flush     = 1'b1;
        req_valid = rv;
        exp_ready = 1'b1;
        model_clear();
        pend_fd = 1;
    endtask

    // mode 0: fill after wait_n cycles; mode 1: reset mid-MISS.
    task automatic lookup(input logic [31:0] addr,
                          input logic [22:0] t1, input logic [22:0] t2,
                          input int wait_n, input int mode,
                          input bit use_lit, input logic lit_hit,
                          input logic lit_way);
        logic [22:0] tag;
        logic [4:0]  i;
        bit          h0, h1, hit, vic, way;
        tag = addr[31:9];
        i   = addr[8:4];

        begin_cycle();
        req_valid = 1'b1;
        req_addr  = addr;
        exp_ready = 1'b1;
        exp_ceb   = 1'b0;
        exp_chk_a = 1;
        exp_a     = i;

        begin_cycle();
        noise();
        ta_TAG1 = t1;
        ta_TAG2 = t2;
        h0  = mv[i][0] && (t1 == tag);
        h1  = mv[i][1] && (t2 == tag);
        hit = h0 || h1;
        if (!mv[i][0]) vic = 0;
        else if (!mv[i][1]) vic = 1;
        else vic = mlru[i];
        way = h0 ? 1'b0 : (h1 ? 1'b1 : vic);

        begin_cycle();
        noise();
        exp_rspv = 1'b1;
        exp_hit  = use_lit ? lit_hit : hit;
        exp_rway = use_lit ? lit_way : way;
        if (hit) begin
            mlru[i] = !way;
            return;
        end

        for (int k = 0; k < wait_n; k++) begin
            begin_cycle();
            noise();
            fill_valid = 1'b0;
        end

        if (mode == 1) begin
            reset_cycle(1'b1);
            reset_cycle(1'b1);
            begin_cycle();
            rst        = 1'b1;
            fill_valid = 1'b1;
            exp_ready  = 1'b1;
            return;
        end

        begin_cycle();
        noise();
        fill_valid  = 1'b1;
        exp_ceb     = 1'b0;
        exp_web     = 1'b0;
        exp_chk_a   = 1;
        exp_chk_way = 1;
        exp_a       = i;
        exp_way     = vic;
        exp_di      = tag;
        mv[i][vic]   = 1;
        mlru[i]      = !vic;
        mtag[i][vic] = tag;

        begin_cycle();
        noise();
        exp_fl = 1'b1;
    endtask

    function automatic logic [22:0] pick(input logic [4:0] i,
                                         input bit w,
                                         input logic [22:0] tag);
        case ($urandom % 4)
            0: pick = tag;
            1: pick = mtag[i][w];
            default: pick = 23'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  ix;
        logic [22:0] tg;
        logic [31:0] ad;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        flush      = 1'b0;
        fill_valid = 1'b0;
        ta_TAG1    = '0;
        ta_TAG2    = '0;
        for (int s = 0; s < 32; s++) begin
            mtag[s][0] = '0;
            mtag[s][1] = '0;
        end
        model_clear();
        chk_en = 1;

        reset_cycle(1'b0);
        reset_cycle(1'b1);
        begin_cycle();
        rst       = 1'b1;
        exp_ready = 1'b1;
        idle_cycle(1'b1);

        // Cold miss, idx 3, tag 0x9, victim way 0.
        lookup(32'h0000_1230, 23'h9, 23'h9, 2, 0, 1, 1'b0, 1'b0);
        // Hit in way 0.
        lookup(32'h0000_1230, 23'h9, 23'h5, 0, 0, 1, 1'b1, 1'b0);
        // Tag 0x11 misses, fills way 1.
        lookup(32'h0000_2230, 23'h9, 23'h11, 1, 0, 1, 1'b0, 1'b1);
        // Hit way 0 again so way 1 becomes LRU.
        lookup(32'h0000_1230, 23'h9, 23'h11, 0, 0, 1, 1'b1, 1'b0);
        // Tag 0x19 misses, evicts LRU way 1.
        lookup(32'h0000_3230, 23'h9, 23'h11, 3, 0, 1, 1'b0, 1'b1);
        // Hit the replaced line in way 1.
        lookup(32'h0000_3230, 23'h9, 23'h19, 0, 0, 1, 1'b1, 1'b1);

        // Flush wins over a simultaneous request.
        do_flush(1'b1);
        // Stale tag match must miss; hold 50 cycles, then reset.
        lookup(32'h0000_1230, 23'h9, 23'h9, 50, 1, 1, 1'b0, 1'b0);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom % 20);
            if (r == 0) begin
                do_flush(1'($urandom));
            end else if (r < 3) begin
                idle_cycle(1'($urandom));
            end else begin
                case ($urandom % 4)
                    0: ix = 5'd3;
                    1: ix = 5'd7;
                    2: ix = 5'd12;
                    default: ix = 5'd31;
                endcase
                case ($urandom % 4)
                    0: tg = 23'h5;
                    1: tg = 23'h9;
                    2: tg = 23'h7FFFFF;
                    default: tg = 23'h123;
                endcase
                ad = {tg, ix, 4'($urandom)};
                lookup(ad, pick(ix, 0, tg), pick(ix, 1, tg),
                       int'($urandom % 4), 0, 0, 1'b0, 1'b0);
            end
        end
        idle_cycle(1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
